// File: rtl/hunch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hunch_pkg
//  Description : Shared types and helpers for the N-player hunch game
//                controller: FSM state encoding, player-count bound and a
//                popcount over the widest supported player vector.
//  Revision    : 1.0  initial release
// ============================================================================
package hunch_pkg;

   localparam int MAX_PLAYERS = 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARM    = 2'd1,
      S_PLAY   = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   // Number of set bits in a player vector padded to MAX_PLAYERS.
   function automatic logic [3:0] popcount8(input logic [MAX_PLAYERS-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < MAX_PLAYERS; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hunch_score_bank.sv
`default_nettype none
// ============================================================================
//  Module      : hunch_score_bank
//  Description : Bank of per-player saturating win counters. CLR wipes every
//                counter and wins over an increment in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module hunch_score_bank #(
   parameter int NUM_PLAYERS = 4,
   parameter int SCORE_W     = 4
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           CLR,
   input  logic [NUM_PLAYERS-1:0]         INC,
   output logic [NUM_PLAYERS*SCORE_W-1:0] SCORES
);

   localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

   generate
      for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_ctr
         logic [SCORE_W-1:0] r_cnt;

         // Saturating win counter for one player; clear takes priority.
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               r_cnt <= '0;
            end else if (CLR) begin
               r_cnt <= '0;
            end else if (INC[g] && (r_cnt != c_SCORE_MAX)) begin
               r_cnt <= r_cnt + SCORE_W'(1);
            end
         end

         assign SCORES[g*SCORE_W +: SCORE_W] = r_cnt;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/hunch_game_n.sv
`default_nettype none
// ============================================================================
//  Module      : hunch_game_n
//  Description : N-player hunch game round controller (2..8 players). Players
//                stand one at a time; simultaneous standers lose, the last
//                seated player loses, and a silence timeout makes every seated
//                player lose. Produces winner/loser masks, a DONE strobe and
//                saturating per-player win counters.
//  Revision    : 1.0  initial release
// ============================================================================
module hunch_game_n
   import hunch_pkg::*;
#(
   parameter int NUM_PLAYERS    = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int SCORE_W        = 4
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           START,
   input  logic                           CLR_SCORE,
   input  logic [NUM_PLAYERS-1:0]         STAND,
   output logic [NUM_PLAYERS-1:0]         STAND_DISP,
   output logic                           ARMED,
   output logic                           DONE,
   output logic [NUM_PLAYERS-1:0]         WINNER_MASK,
   output logic [NUM_PLAYERS-1:0]         LOSER_MASK,
   output logic                           TIMED_OUT,
   output logic [NUM_PLAYERS*SCORE_W-1:0] SCORES
);

   // A zero TIMEOUT_CYCLES disables the timeout; keep a 1-bit counter then.
   localparam bit            c_TO_EN = (TIMEOUT_CYCLES != 0);
   localparam int            c_TW    = c_TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [c_TW-1:0] c_TLAST = c_TO_EN ? c_TW'(TIMEOUT_CYCLES - 1) : '0;

   state_t                  r_state, w_state_nxt;
   logic [NUM_PLAYERS-1:0]  r_stood, w_stood_nxt;
   logic [NUM_PLAYERS-1:0]  r_win, w_win_nxt;
   logic [NUM_PLAYERS-1:0]  r_lose, w_lose_nxt;
   logic                    r_to, w_to_nxt;
   logic [c_TW-1:0]         r_tcnt, w_tcnt_nxt;
   logic [NUM_PLAYERS-1:0]  r_stand_disp;

   logic [NUM_PLAYERS-1:0]  w_new, w_rem;
   logic [MAX_PLAYERS-1:0]  w_new8, w_rem8;
   logic [3:0]              w_new_cnt, w_rem_cnt;
   logic [NUM_PLAYERS-1:0]  w_score_inc;

   // Newly standing players this cycle and players still seated.
   assign w_new = STAND & ~r_stood;
   assign w_rem = ~r_stood;

   // Pad the player vectors to the package popcount width.
   always_comb begin
      w_new8 = '0;
      w_rem8 = '0;
      w_new8[NUM_PLAYERS-1:0] = w_new;
      w_rem8[NUM_PLAYERS-1:0] = w_rem;
   end

   assign w_new_cnt = popcount8(w_new8);
   assign w_rem_cnt = popcount8(w_rem8);

   // Next-state and round bookkeeping decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_stood_nxt = r_stood;
      w_win_nxt   = r_win;
      w_lose_nxt  = r_lose;
      w_to_nxt    = r_to;
      w_tcnt_nxt  = r_tcnt;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_state_nxt = S_ARM;
               w_stood_nxt = '0;
               w_win_nxt   = '0;
               w_lose_nxt  = '0;
               w_to_nxt    = 1'b0;
               w_tcnt_nxt  = '0;
            end
         end
         S_ARM: begin
            // Only start play once every player is seated.
            if (STAND == '0) begin
               w_state_nxt = S_PLAY;
            end
         end
         S_PLAY: begin
            if (w_new_cnt >= 4'd2) begin
               // Collision: everyone who stood together loses.
               w_lose_nxt  = w_new;
               w_win_nxt   = r_stood;
               w_state_nxt = S_RESULT;
            end else if (w_new_cnt == 4'd1) begin
               w_stood_nxt = r_stood | w_new;
               w_tcnt_nxt  = '0;
               if (w_rem_cnt <= 4'd2) begin
                  // One seat left after this stand: that player loses.
                  w_win_nxt   = r_stood | w_new;
                  w_lose_nxt  = w_rem & ~w_new;
                  w_state_nxt = S_RESULT;
               end
            end else if (c_TO_EN) begin
               if (r_tcnt == c_TLAST) begin
                  w_lose_nxt  = w_rem;
                  w_win_nxt   = r_stood;
                  w_to_nxt    = 1'b1;
                  w_state_nxt = S_RESULT;
               end else begin
                  w_tcnt_nxt = r_tcnt + c_TW'(1);
               end
            end
         end
         S_RESULT: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, masks, timeout counter and stand display registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= S_IDLE;
         r_stood      <= '0;
         r_win        <= '0;
         r_lose       <= '0;
         r_to         <= 1'b0;
         r_tcnt       <= '0;
         r_stand_disp <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_stood      <= w_stood_nxt;
         r_win        <= w_win_nxt;
         r_lose       <= w_lose_nxt;
         r_to         <= w_to_nxt;
         r_tcnt       <= w_tcnt_nxt;
         r_stand_disp <= STAND;
      end
   end

   // Winners of the round are credited on the edge that leaves RESULT.
   assign w_score_inc = (r_state == S_RESULT) ? r_win : '0;

   hunch_score_bank #(
      .NUM_PLAYERS (NUM_PLAYERS),
      .SCORE_W     (SCORE_W)
   ) u_score_bank (
      .CLK    (CLK),
      .RST    (RST),
      .CLR    (CLR_SCORE),
      .INC    (w_score_inc),
      .SCORES (SCORES)
   );

   assign STAND_DISP  = r_stand_disp;
   assign ARMED       = (r_state == S_PLAY);
   assign DONE        = (r_state == S_RESULT);
   assign WINNER_MASK = r_win;
   assign LOSER_MASK  = r_lose;
   assign TIMED_OUT   = r_to;

endmodule
`default_nettype wire

// File: tb/tb_hunch_game_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hunch_game_n
//  Description : Self-checking bench for hunch_game_n (4 players, timeout of
//                5 cycles, 2-bit scores) using a vector table plus directed
//                sequences for saturation, clear, arming and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hunch_game_n;

   localparam int N  = 4;
   localparam int T  = 5;
   localparam int SW = 2;

   typedef struct {
      logic       start;
      logic [3:0] stand;
      logic       clr;
      logic       armed;
      logic       done;
      logic [3:0] win;
      logic [3:0] lose;
      logic       tout;
      logic [7:0] scores;
   } vec_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          START = 1'b0;
   logic          CLR_SCORE = 1'b0;
   logic [N-1:0]  STAND = '0;
   logic [N-1:0]  STAND_DISP;
   logic          ARMED;
   logic          DONE;
   logic [N-1:0]  WINNER_MASK;
   logic [N-1:0]  LOSER_MASK;
   logic          TIMED_OUT;
   logic [N*SW-1:0] SCORES;

   int   checks = 0;
   int   passes = 0;
   vec_t tbl[21];

   hunch_game_n #(
      .NUM_PLAYERS    (N),
      .TIMEOUT_CYCLES (T),
      .SCORE_W        (SW)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .START       (START),
      .CLR_SCORE   (CLR_SCORE),
      .STAND       (STAND),
      .STAND_DISP  (STAND_DISP),
      .ARMED       (ARMED),
      .DONE        (DONE),
      .WINNER_MASK (WINNER_MASK),
      .LOSER_MASK  (LOSER_MASK),
      .TIMED_OUT   (TIMED_OUT),
      .SCORES      (SCORES)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply(input int idx, input string tag);
      vec_t v;
      v = tbl[idx];
      START     = v.start;
      STAND     = v.stand;
      CLR_SCORE = v.clr;
      step();
      chk($sformatf("%s[%0d] ARMED", tag, idx),       32'(ARMED),       32'(v.armed));
      chk($sformatf("%s[%0d] DONE", tag, idx),        32'(DONE),        32'(v.done));
      chk($sformatf("%s[%0d] WINNER", tag, idx),      32'(WINNER_MASK), 32'(v.win));
      chk($sformatf("%s[%0d] LOSER", tag, idx),       32'(LOSER_MASK),  32'(v.lose));
      chk($sformatf("%s[%0d] TIMED_OUT", tag, idx),   32'(TIMED_OUT),   32'(v.tout));
      chk($sformatf("%s[%0d] SCORES", tag, idx),      32'(SCORES),      32'(v.scores));
      chk($sformatf("%s[%0d] STAND_DISP", tag, idx),  32'(STAND_DISP),  32'(v.stand));
   endtask

   // Player 0 stands alone, then players 1 and 2 collide: player 0 wins.
   task automatic p0_round(input int r, input logic clr, input logic [7:0] exp_sc);
      START = 1'b1; STAND = 4'b0000; step();
      START = 1'b0; step();
      chk($sformatf("p0r%0d ARMED", r), 32'(ARMED), 32'd1);
      STAND = 4'b0001; step();
      STAND = 4'b0111; step();
      chk($sformatf("p0r%0d DONE", r),   32'(DONE),        32'd1);
      chk($sformatf("p0r%0d WINNER", r), 32'(WINNER_MASK), 32'h1);
      chk($sformatf("p0r%0d LOSER", r),  32'(LOSER_MASK),  32'h6);
      CLR_SCORE = clr; STAND = 4'b0000; step();
      CLR_SCORE = 1'b0;
      chk($sformatf("p0r%0d DONE low", r), 32'(DONE),   32'd0);
      chk($sformatf("p0r%0d SCORES", r),   32'(SCORES), 32'(exp_sc));
   endtask

   initial begin
      //          start stand    clr armed done win      lose     to    scores
      // Round A: singles 0,1,2 -> player 3 is last seated.
      tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[3]  = '{1'b0, 4'b0011, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};
      tbl[4]  = '{1'b0, 4'b0111, 1'b0, 1'b0, 1'b1, 4'b0111, 4'b1000, 1'b0, 8'h00};
      tbl[5]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b1000, 1'b0, 8'h15};
      tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b1000, 1'b0, 8'h15};
      // Round B: player 3 stands, then players 0 and 2 collide.
      tbl[7]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h15};
      tbl[8]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h15};
      tbl[9]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h15};
      tbl[10] = '{1'b0, 4'b1101, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b0101, 1'b0, 8'h15};
      tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0101, 1'b0, 8'h55};
      // Round C: player 1 stands, then 5 silent cycles (START in PLAY ignored).
      tbl[12] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h55};
      tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h55};
      tbl[14] = '{1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h55};
      tbl[15] = '{1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h55};
      tbl[16] = '{1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h55};
      tbl[17] = '{1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h55};
      tbl[18] = '{1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h55};
      tbl[19] = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b1101, 1'b1, 8'h55};
      tbl[20] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b1101, 1'b1, 8'h59};

      // Reset state.
      repeat (2) @(posedge CLK);
      #1;
      chk("reset ARMED",      32'(ARMED),       32'd0);
      chk("reset DONE",       32'(DONE),        32'd0);
      chk("reset WINNER",     32'(WINNER_MASK), 32'd0);
      chk("reset LOSER",      32'(LOSER_MASK),  32'd0);
      chk("reset TIMED_OUT",  32'(TIMED_OUT),   32'd0);
      chk("reset SCORES",     32'(SCORES),      32'd0);
      chk("reset STAND_DISP", 32'(STAND_DISP),  32'd0);
      RST = 1'b1;

      for (int i = 0; i < 21; i++) apply(i, "tbl");

      // Player 0 wins five rounds: score 1 -> 2 -> 3 then saturates.
      p0_round(1, 1'b0, 8'h5A);
      p0_round(2, 1'b0, 8'h5B);
      p0_round(3, 1'b0, 8'h5B);
      p0_round(4, 1'b0, 8'h5B);
      p0_round(5, 1'b0, 8'h5B);
      // Clear asserted during RESULT beats the increment.
      p0_round(6, 1'b1, 8'h00);

      // Normal round from cleared scores.
      for (int i = 0; i < 7; i++) apply(i, "again");

      // STAND held at START keeps the FSM in ARM.
      START = 1'b1; STAND = 4'b0001; step();
      chk("arm hold 0 ARMED", 32'(ARMED), 32'd0);
      START = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk($sformatf("arm hold %0d ARMED", i), 32'(ARMED), 32'd0);
      end
      STAND = 4'b0000; step();
      chk("arm release ARMED", 32'(ARMED), 32'd1);
      STAND = 4'b0001; step();
      chk("play stand ARMED", 32'(ARMED), 32'd1);
      START = 1'b1; step();
      chk("play start ARMED", 32'(ARMED), 32'd1);
      chk("play start DONE",  32'(DONE),  32'd0);
      START = 1'b0; STAND = 4'b0011; step();
      chk("play second ARMED", 32'(ARMED), 32'd1);

      // Asynchronous reset in the middle of PLAY.
      #2;
      RST = 1'b0;
      #1;
      chk("midreset ARMED",      32'(ARMED),       32'd0);
      chk("midreset DONE",       32'(DONE),        32'd0);
      chk("midreset SCORES",     32'(SCORES),      32'd0);
      chk("midreset STAND_DISP", 32'(STAND_DISP),  32'd0);
      chk("midreset WINNER",     32'(WINNER_MASK), 32'd0);
      chk("midreset LOSER",      32'(LOSER_MASK),  32'd0);
      STAND = 4'b0000;
      @(negedge CLK);
      RST = 1'b1;
      step();

      // A fresh round after reset behaves normally.
      for (int i = 0; i < 7; i++) apply(i, "post");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
